// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals between the fetch side, the decode stage and its consumer.
// The stimulus or upstream side uses master; decode_stage uses slave.
interface decode_stage_if #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [DWIDTH-1:0]    insn_i;
    logic [AWIDTH-1:0]    pc_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 flush_i;
    logic [AWIDTH-1:0]    pc_o;
    logic [DWIDTH-1:0]    insn_o;
    logic [6:0]           opcode_o;
    logic [4:0]           rd_o;
    logic [4:0]           rs1_o;
    logic [4:0]           rs2_o;
    logic [2:0]           funct3_o;
    logic [6:0]           funct7_o;
    logic [4:0]           shamt_o;
    logic [DWIDTH-1:0]    imm_o;
    logic                 illegal_o;
    logic [CNT_WIDTH-1:0] count_o;

    modport master (
        output in_valid_i, insn_i, pc_i, out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7_o, shamt_o, imm_o, illegal_o, count_o
    );

    modport slave (
        input  in_valid_i, insn_i, pc_i, out_ready_i, flush_i,
        output in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
               funct3_o, funct7_o, shamt_o, imm_o, illegal_o, count_o
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a two-entry output/skid buffer. in_ready comes straight from the
// state register, so there is no combinational path from the consumer's ready back upstream.
module decode_stage #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        shamt;
        logic [DWIDTH-1:0] imm;
        logic              illegal;
    } bundle_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]           state_reg, state_next;
    bundle_t              out_reg, out_next;
    bundle_t              skid_reg, skid_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    bundle_t              dec;
    bundle_t              shown;
    logic                 is_r, is_i, is_s, is_b, is_u, is_j, is_shift;
    logic [31:0]          insn;
    logic                 accept, xfer;

    assign insn = bus.insn_i;

    always_comb begin
        is_r = 1'b0;
        is_i = 1'b0;
        is_s = 1'b0;
        is_b = 1'b0;
        is_u = 1'b0;
        is_j = 1'b0;
        case (insn[6:0])
            7'b0110011:                         is_r = 1'b1;
            7'b0010011, 7'b0000011, 7'b1100111: is_i = 1'b1;
            7'b0100011:                         is_s = 1'b1;
            7'b1100011:                         is_b = 1'b1;
            7'b0110111, 7'b0010111:             is_u = 1'b1;
            7'b1101111:                         is_j = 1'b1;
            default: ;
        endcase
        is_shift = (insn[6:0] == 7'b0010011) && (insn[14:12] == 3'b001 || insn[14:12] == 3'b101);

        // Every field not owned by the format stays zero, which also covers illegal opcodes.
        dec         = '0;
        dec.pc      = bus.pc_i;
        dec.insn    = insn;
        dec.opcode  = insn[6:0];
        dec.illegal = !(is_r || is_i || is_s || is_b || is_u || is_j);
        if (is_r || is_i || is_u || is_j) dec.rd = insn[11:7];
        if (is_r || is_i || is_s || is_b) begin
            dec.rs1    = insn[19:15];
            dec.funct3 = insn[14:12];
        end
        if (is_r || is_s || is_b) dec.rs2    = insn[24:20];
        if (is_r || is_shift)     dec.funct7 = insn[31:25];
        if (is_shift)             dec.shamt  = insn[24:20];
        if (is_i) dec.imm = {{20{insn[31]}}, insn[31:20]};
        if (is_s) dec.imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        if (is_b) dec.imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        if (is_u) dec.imm = {insn[31:12], 12'b0};
        if (is_j) dec.imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    end

    assign accept = bus.in_valid_i && (state_reg != FULL);
    assign xfer   = (state_reg != EMPTY) && bus.out_ready_i;

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        skid_next  = skid_reg;
        count_next = count_reg;
        if (bus.flush_i) begin
            state_next = EMPTY;
        end else begin
            if (xfer) count_next = count_reg + 1'b1;
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        out_next   = dec;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        out_next = dec;
                    end else if (accept) begin
                        skid_next  = dec;
                        state_next = FULL;
                    end else if (xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        out_next   = skid_reg;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            skid_reg  <= skid_next;
            count_reg <= count_next;
        end
    end

    assign bus.out_valid_o = (state_reg != EMPTY);
    assign bus.in_ready_o  = (state_reg != FULL);
    assign shown           = bus.out_valid_o ? out_reg : '0;
    assign bus.pc_o        = shown.pc;
    assign bus.insn_o      = shown.insn;
    assign bus.opcode_o    = shown.opcode;
    assign bus.rd_o        = shown.rd;
    assign bus.rs1_o       = shown.rs1;
    assign bus.rs2_o       = shown.rs2;
    assign bus.funct3_o    = shown.funct3;
    assign bus.funct7_o    = shown.funct7;
    assign bus.shamt_o     = shown.shamt;
    assign bus.imm_o       = shown.imm;
    assign bus.illegal_o   = shown.illegal;
    assign bus.count_o     = count_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues hand-computed bundles as inputs are
// accepted, and a negedge monitor checks every output transfer, the idle zeroing and count_o.
module tb_decode_stage;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if #(.AWIDTH(AW), .DWIDTH(DW), .CNT_WIDTH(CW)) bus ();
    decode_stage #(.AWIDTH(AW), .DWIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sbq[$];
    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;
    int   n_xfer  = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] insn,
                                input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] sh, input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.insn = insn; e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.shamt = sh; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    // Monitor: compares only at negedges, where every DUT output and bench input is settled.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(bus.count_o), 32'(exp_cnt));
            if (!bus.out_valid_o) begin
                chk("idle_pc", bus.pc_o, 32'h0);
                chk("idle_insn_imm", bus.insn_o | bus.imm_o, 32'h0);
                chk("idle_fields", {1'b0, bus.illegal_o, bus.rd_o, bus.rs1_o, bus.rs2_o,
                                    bus.funct3_o, bus.funct7_o, bus.shamt_o}, 32'h0);
                chk("idle_opcode", 32'(bus.opcode_o), 32'h0);
            end
            if (rst) begin
                exp_cnt = 0;
            end else if (bus.out_valid_o && bus.out_ready_i && !bus.flush_i) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got insn 0x%08h want no transfer", bus.insn_o);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_xfer++;
                    $display("xfer %0d pc=0x%08h insn=0x%08h imm=0x%08h ill=%0b",
                             n_xfer, bus.pc_o, bus.insn_o, bus.imm_o, bus.illegal_o);
                    chk("pc",      bus.pc_o,              e.pc);
                    chk("insn",    bus.insn_o,            e.insn);
                    chk("opcode",  32'(bus.opcode_o),     32'(e.opcode));
                    chk("rd",      32'(bus.rd_o),         32'(e.rd));
                    chk("rs1",     32'(bus.rs1_o),        32'(e.rs1));
                    chk("rs2",     32'(bus.rs2_o),        32'(e.rs2));
                    chk("funct3",  32'(bus.funct3_o),     32'(e.f3));
                    chk("funct7",  32'(bus.funct7_o),     32'(e.f7));
                    chk("shamt",   32'(bus.shamt_o),      32'(e.shamt));
                    chk("imm",     bus.imm_o,             e.imm);
                    chk("illegal", 32'(bus.illegal_o),    32'(e.ill));
                end
                exp_cnt = (exp_cnt + 1) % 16;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction and waits (bounded) for acceptance; expectation is queued first.
    task automatic send(input exp_t e);
        bit ok;
        ok = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.insn_i     = e.insn;
        bus.pc_i       = e.pc;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready_o) begin
                sbq.push_back(e);
                tick(1);
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        bus.in_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want acceptance of 0x%08h", e.insn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        exp_t addi, srai, bne, jal, sub_i, sw, lui, ill;
        int   c0;
        addi  = mk(32'h100, 32'hFFF30293, 7'h13,  5,  6, 0, 3'd0, 7'h00, 0, 32'hFFFFFFFF, 1'b0);
        srai  = mk(32'h104, 32'h40765593, 7'h13, 11, 12, 0, 3'd5, 7'h20, 7, 32'h00000407, 1'b0);
        bne   = mk(32'h108, 32'hFE209EE3, 7'h63,  0,  1, 2, 3'd1, 7'h00, 0, 32'hFFFFFFFC, 1'b0);
        jal   = mk(32'h10C, 32'h800001EF, 7'h6F,  3,  0, 0, 3'd0, 7'h00, 0, 32'hFFF00000, 1'b0);
        sub_i = mk(32'h110, 32'h409403B3, 7'h33,  7,  8, 9, 3'd0, 7'h20, 0, 32'h00000000, 1'b0);
        sw    = mk(32'h114, 32'hFE512E23, 7'h23,  0,  2, 5, 3'd2, 7'h00, 0, 32'hFFFFFFFC, 1'b0);
        lui   = mk(32'h118, 32'h12345537, 7'h37, 10,  0, 0, 3'd0, 7'h00, 0, 32'h12345000, 1'b0);
        ill   = mk(32'h11C, 32'h0000007F, 7'h7F,  0,  0, 0, 3'd0, 7'h00, 0, 32'h00000000, 1'b1);

        bus.in_valid_i  = 1'b0;
        bus.insn_i      = '0;
        bus.pc_i        = '0;
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b0;
        rst             = 1'b1;
        tick(2);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
        chk("rst_count",     32'(bus.count_o),     32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single ADDI with a ready consumer: visible one cycle after acceptance.
        bus.out_ready_i = 1'b1;
        send(addi);
        chk("addi_latency_valid", 32'(bus.out_valid_o), 32'd1);
        tick(1);
        chk("addi_count", 32'(bus.count_o), 32'd1);
        chk("addi_drained", 32'(bus.out_valid_o), 32'd0);

        // Backpressure: two accepted, third held until the consumer releases.
        bus.out_ready_i = 1'b0;
        send(srai);
        send(bne);
        chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
        bus.in_valid_i = 1'b1;
        bus.insn_i     = jal.insn;
        bus.pc_i       = jal.pc;
        tick(3);
        chk("held_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("held_out_valid", 32'(bus.out_valid_o), 32'd1);
        chk("held_insn", bus.insn_o, srai.insn);
        bus.out_ready_i = 1'b1;
        send(jal);
        tick(4);
        chk("drain_in_order", 32'(sbq.size()), 32'd0);

        // Remaining formats back to back, including an unknown opcode.
        send(sub_i);
        send(sw);
        send(lui);
        send(ill);
        tick(3);

        // Consumer ready toggles every cycle while instructions stream in.
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    bus.out_ready_i = (i % 2 == 1);
                    tick(1);
                end
                bus.out_ready_i = 1'b1;
            end
            begin
                send(mk(32'h200, addi.insn, 7'h13, 5, 6, 0, 3'd0, 7'h00, 0, 32'hFFFFFFFF, 1'b0));
                send(mk(32'h204, sw.insn, 7'h23, 0, 2, 5, 3'd2, 7'h00, 0, 32'hFFFFFFFC, 1'b0));
                send(mk(32'h208, bne.insn, 7'h63, 0, 1, 2, 3'd1, 7'h00, 0, 32'hFFFFFFFC, 1'b0));
                send(mk(32'h20C, lui.insn, 7'h37, 10, 0, 0, 3'd0, 7'h00, 0, 32'h12345000, 1'b0));
            end
        join
        tick(6);
        chk("toggle_drained", 32'(sbq.size()), 32'd0);

        // Flush while full, with a new input and a ready consumer in the same cycle.
        bus.out_ready_i = 1'b0;
        send(sub_i);
        send(lui);
        chk("pre_flush_full", 32'(bus.in_ready_o), 32'd0);
        c0 = int'(bus.count_o);
        bus.in_valid_i  = 1'b1;
        bus.insn_i      = sw.insn;
        bus.pc_i        = sw.pc;
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        sbq.delete();
        tick(1);
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready_o),  32'd1);
        chk("flush_count",     32'(bus.count_o),     32'(c0));
        tick(2);
        chk("flush_dropped_input", 32'(bus.out_valid_o), 32'd0);

        // Sixteen transfers bring the 4-bit counter back to where it started.
        bus.out_ready_i = 1'b1;
        c0 = int'(bus.count_o);
        for (int i = 0; i < 16; i++)
            send(mk(32'h300 + 32'(i * 4), addi.insn, 7'h13, 5, 6, 0, 3'd0, 7'h00, 0, 32'hFFFFFFFF, 1'b0));
        tick(2);
        chk("count_wrap", 32'(bus.count_o), 32'(c0));

        // Reset while full dominates flush and a presented input.
        bus.out_ready_i = 1'b0;
        send(srai);
        send(jal);
        chk("pre_rst_full", 32'(bus.in_ready_o), 32'd0);
        rst            = 1'b1;
        bus.flush_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.insn_i     = bne.insn;
        bus.pc_i       = bne.pc;
        tick(1);
        sbq.delete();
        chk("rst_full_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_full_in_ready",  32'(bus.in_ready_o),  32'd1);
        chk("rst_full_count",     32'(bus.count_o),     32'd0);
        chk("rst_full_pc",        bus.pc_o,             32'd0);
        chk("rst_full_insn_imm",  bus.insn_o | bus.imm_o, 32'd0);
        rst            = 1'b0;
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        tick(2);
        chk("post_rst_idle", 32'(bus.out_valid_o), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters: AWIDTH, default 32, PC width; DWIDTH, default 32, instruction/immediate width (32 only is legal); CNT_WIDTH, default 16, decode counter width.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-003 SHALL have ports: in_valid_i  in  1  instruction present; in_ready_o  out  1  stage can accept; insn_i  in  DWIDTH  instruction; pc_i  in  AWIDTH  instruction PC.
REQ-004 SHALL have ports: out_valid_o  out  1  decoded bundle present; out_ready_i  in  1  consumer accepts; flush_i  in  1  discard all held entries.
REQ-005 SHALL have outputs: pc_o AWIDTH; insn_o DWIDTH; opcode_o 7; rd_o 5; rs1_o 5; rs2_o 5; funct3_o 3; funct7_o 7; shamt_o 5; imm_o DWIDTH; illegal_o 1 (unrecognised opcode); count_o CNT_WIDTH (completed output handshakes).
REQ-006 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-007 SHALL hold up to two decoded entries: output register (OUT) and skid register (SKID); states EMPTY, ONE (OUT valid), FULL (OUT and SKID valid).
REQ-008 SHALL drive in_ready_o = !SKID valid, from a register (no combinational path from out_ready_i).
REQ-009 SHALL accept an input when in_valid_i && in_ready_o at a rising edge; the decoded bundle is visible on the outputs the following cycle at the earliest (latency 1).
REQ-010 SHALL complete an output transfer when out_valid_o && out_ready_i; outputs hold stable while out_valid_o && !out_ready_i.
REQ-011 Transitions: EMPTY+accept -> ONE; ONE+accept+transfer -> ONE (OUT replaced); ONE+accept+!transfer -> FULL (new entry to SKID); ONE+transfer+!accept -> EMPTY; FULL+transfer -> ONE (SKID moves to OUT); otherwise hold.
REQ-012 SHALL preserve program order; no entry is dropped or duplicated absent flush.
REQ-013 flush_i SHALL take priority: next state EMPTY, input presented that cycle discarded, count_o not incremented for any transfer that cycle.
REQ-014 Decode: opcode=insn[6:0]; formats R 0110011; I 0010011, 0000011, 1100111; S 0100011; B 1100011; U 0110111, 0010111; J 1101111.
REQ-015 Fields not used by the format SHALL be 0: rd for S/B; rs1 for U/J; rs2 for I/U/J; funct3 for U/J; funct7 except R and I-shifts (opcode 0010011, funct3 001/101).
REQ-016 shamt_o SHALL be insn[24:20] for I-shifts, else 0.
REQ-017 imm_o SHALL be sign-extended per format: I insn[31:20] (shifts included, raw 12 bits); S {insn[31:25],insn[11:7]}; B {insn[31],insn[7],insn[30:25],insn[11:8],0}; U {insn[31:12],12'b0}; J {insn[31],insn[19:12],insn[20],insn[30:21],0}; R 0.
REQ-018 Unknown opcode SHALL set illegal_o=1 with rd/rs1/rs2/funct3/funct7/shamt/imm = 0; pc_o, insn_o, opcode_o pass through.
REQ-019 count_o SHALL increment by 1 per output transfer, wrapping from all-ones to 0.
REQ-020 Bundle outputs SHALL be 0 whenever out_valid_o=0.

Reset
REQ-021 On rst=1 at an edge: state EMPTY, out_valid_o=0, in_ready_o=1, all bundle outputs 0, count_o=0.
REQ-022 rst mid-operation SHALL discard both entries; rst dominates flush_i and in_valid_i.

Verification
REQ-023 ADDI x5,x6,-1 (0xFFF30293), pc 0x100, out_ready=1 -> next cycle out_valid=1, rd=5, rs1=6, rs2=0, imm=0xFFFFFFFF, count=1 after transfer.
REQ-024 out_ready=0, three back-to-back inputs -> first two accepted, in_ready=0 after second, third held; release out_ready -> outputs in order, no loss.
REQ-025 SRAI x11,x12,7 -> funct7=0x20, shamt=7, imm=0x00000407; BNE x1,x2,-4 -> rd=0, imm=0xFFFFFFFC; JAL x3,-1MB -> imm=0xFFF00000.
REQ-026 insn 0x0000007F -> illegal_o=1, imm=0, opcode=0x7F.
REQ-027 State FULL, flush_i=1 with in_valid_i=1 -> next cycle out_valid=0, in_ready=1, count unchanged.
REQ-028 CNT_WIDTH=4, 16 transfers -> count_o wraps to 0; rst in FULL -> all outputs 0 next cycle.
